// File: rtl/servisia_gpio_pkg.sv
// Shared register map and bus FSM encoding for the GPIO peripheral.
// No logic lives here. The constants carry no timing and no backpressure.
package servisia_gpio_pkg;

   localparam logic [2:0] ADR_OUT  = 3'd0;
   localparam logic [2:0] ADR_DIR  = 3'd1;
   localparam logic [2:0] ADR_IN   = 3'd2;
   localparam logic [2:0] ADR_RISE = 3'd3;
   localparam logic [2:0] ADR_FALL = 3'd4;

   typedef enum logic {
      ST_IDLE = 1'b0,
      ST_ACK  = 1'b1
   } bus_state_t;

endpackage

// File: rtl/servisia_sync.sv
// Two-flop synchroniser that brings asynchronous pin inputs into the clock domain.
// Output lags the pin by 2 cycles. It has no backpressure and samples every cycle.
module servisia_sync #(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [WIDTH-1:0] d,
   output logic [WIDTH-1:0] q
);

   logic [WIDTH-1:0] meta_q;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         meta_q <= '0;
         q      <= '0;
      end else begin
         meta_q <= d;
         q      <= meta_q;
      end
   end

endmodule

// File: rtl/servisia_gpio.sv
// Wishbone GPIO peripheral; edge flags and irq are built only with SERVISIA_GPIO_EDGE_EN.
// Each access is acked 1 cycle after stb and occupies 2 cycles.
// There is no backpressure beyond ack, and a held stb is re-served only after the ACK state.
module servisia_gpio
   import servisia_gpio_pkg::*;
#(
   parameter int WIDTH = 8
) (
   input  logic             wb_clk_i,
   input  logic             wb_rst_i,
   input  logic [2:0]       wb_adr_i,
   input  logic [31:0]      wb_dat_i,
   input  logic             wb_we_i,
   input  logic             wb_stb_i,
   output logic [31:0]      wb_rdt_o,
   output logic             wb_ack_o,
   input  logic [WIDTH-1:0] gpio_i,
   output logic [WIDTH-1:0] gpio_o,
   output logic [WIDTH-1:0] gpio_oe_o,
   output logic             irq_o
);

   bus_state_t       state_q, state_d;
   logic             access;
   logic             wr_en;
   logic [WIDTH-1:0] wr_dat;
   logic [WIDTH-1:0] out_q, dir_q, in_sync;
   logic [WIDTH-1:0] rise_q, fall_q;
   logic [31:0]      rd_word;
   logic             unused_dat;

   assign unused_dat = ^wb_dat_i;

   always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
      if (wb_rst_i) state_q <= ST_IDLE;
      else          state_q <= state_d;
   end

   // An access fires only from IDLE, so a stb held through ACK is not served twice.
   always_comb begin
      state_d = state_q;
      access  = 1'b0;
      case (state_q)
         ST_IDLE: if (wb_stb_i) begin
            access  = 1'b1;
            state_d = ST_ACK;
         end
         ST_ACK:  state_d = ST_IDLE;
      endcase
   end

   assign wb_ack_o = (state_q == ST_ACK);
   assign wr_en    = access & wb_we_i;
   assign wr_dat   = wb_dat_i[WIDTH-1:0];

   always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
      if (wb_rst_i) begin
         out_q <= '0;
         dir_q <= '0;
      end else if (wr_en) begin
         if (wb_adr_i == ADR_OUT) out_q <= wr_dat;
         if (wb_adr_i == ADR_DIR) dir_q <= wr_dat;
      end
   end

   assign gpio_o    = out_q;
   assign gpio_oe_o = dir_q;

   servisia_sync #(.WIDTH(WIDTH)) u_sync (
      .clk (wb_clk_i),
      .rst (wb_rst_i),
      .d   (gpio_i),
      .q   (in_sync)
   );

`ifdef SERVISIA_GPIO_EDGE_EN
   logic [WIDTH-1:0] prev_q, rise_clr, fall_clr;
   logic             irq_q;

   assign rise_clr = (wr_en && wb_adr_i == ADR_RISE) ? wr_dat : '0;
   assign fall_clr = (wr_en && wb_adr_i == ADR_FALL) ? wr_dat : '0;

   // The set term is ORed in after the clear, so a new edge beats a same-cycle w1c.
   always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
      if (wb_rst_i) begin
         prev_q <= '0;
         rise_q <= '0;
         fall_q <= '0;
         irq_q  <= 1'b0;
      end else begin
         prev_q <= in_sync;
         rise_q <= (rise_q & ~rise_clr) | (in_sync & ~prev_q);
         fall_q <= (fall_q & ~fall_clr) | (~in_sync & prev_q);
         irq_q  <= |(rise_q | fall_q);
      end
   end

   assign irq_o = irq_q;
`else
   assign rise_q = '0;
   assign fall_q = '0;
   assign irq_o  = 1'b0;
`endif

   always_comb begin
      rd_word = '0;
      case (wb_adr_i)
         ADR_OUT:  rd_word[WIDTH-1:0] = out_q;
         ADR_DIR:  rd_word[WIDTH-1:0] = dir_q;
         ADR_IN:   rd_word[WIDTH-1:0] = in_sync;
         ADR_RISE: rd_word[WIDTH-1:0] = rise_q;
         ADR_FALL: rd_word[WIDTH-1:0] = fall_q;
         default:  ;
      endcase
   end

   // Read data persists after ack, so it only changes on a read.
   always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
      if (wb_rst_i)                 wb_rdt_o <= '0;
      else if (access && !wb_we_i)  wb_rdt_o <= rd_word;
   end

endmodule

// File: tb/tb_servisia_gpio.sv
// Self-checking bench for servisia_gpio: directed table, hand-written corner sequences,
// and randomised traffic checked against a register-level model.
module tb_servisia_gpio;

   localparam int W = 8;
   localparam logic [31:0] MASK = (32'd1 << W) - 32'd1;
`ifdef SERVISIA_GPIO_EDGE_EN
   localparam bit EDGE = 1'b1;
`else
   localparam bit EDGE = 1'b0;
`endif

   logic          clk = 1'b0;
   logic          rst;
   logic [2:0]    adr;
   logic [31:0]   dat;
   logic          we;
   logic          stb;
   logic [31:0]   rdt;
   logic          ack;
   logic [W-1:0]  pin;
   logic [W-1:0]  gpo;
   logic [W-1:0]  oe;
   logic          irq;

   int checks = 0;
   int errors = 0;

   // Register-level model state.
   logic [31:0] m_out, m_dir, m_pin, m_rise, m_fall;

   servisia_gpio #(.WIDTH(W)) dut (
      .wb_clk_i  (clk),
      .wb_rst_i  (rst),
      .wb_adr_i  (adr),
      .wb_dat_i  (dat),
      .wb_we_i   (we),
      .wb_stb_i  (stb),
      .wb_rdt_o  (rdt),
      .wb_ack_o  (ack),
      .gpio_i    (pin),
      .gpio_o    (gpo),
      .gpio_oe_o (oe),
      .irq_o     (irq)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   // A single access: stb is driven between edges, and ack is expected exactly one edge later.
   task automatic bus(input logic [2:0] a, input logic w, input logic [31:0] d,
                      output logic [31:0] rd);
      @(negedge clk);
      adr = a; we = w; dat = d; stb = 1'b1;
      @(posedge clk); #1;
      check("ack_high", {31'd0, ack}, 32'd1);
      rd  = rdt;
      stb = 1'b0;
      @(posedge clk); #1;
      check("ack_low", {31'd0, ack}, 32'd0);
   endtask

   function automatic logic [31:0] model_read(input logic [2:0] a);
      case (a)
         3'd0:    return m_out;
         3'd1:    return m_dir;
         3'd2:    return m_pin;
         3'd3:    return EDGE ? m_rise : 32'd0;
         3'd4:    return EDGE ? m_fall : 32'd0;
         default: return 32'd0;
      endcase
   endfunction

   typedef struct {
      logic [2:0]  adr;
      logic        we;
      logic [31:0] dat;
      logic [31:0] exp_rd;
      logic [W-1:0] exp_o;
      logic [W-1:0] exp_oe;
   } vec_t;

   vec_t vecs[10];

   initial begin
      logic [31:0] rd;
      logic [W-1:0] nxt;
      int acks;

      rst = 1'b1; adr = '0; dat = '0; we = 1'b0; stb = 1'b0; pin = '0;
      repeat (3) @(posedge clk);
      #1;
      check("rst_gpio_o", {24'd0, gpo}, 32'd0);
      check("rst_oe", {24'd0, oe}, 32'd0);
      check("rst_ack", {31'd0, ack}, 32'd0);
      check("rst_rdt", rdt, 32'd0);
      check("rst_irq", {31'd0, irq}, 32'd0);
      @(negedge clk); rst = 1'b0;

      // Reset asserted while a write to OUT is being acked.
      bus(3'd0, 1'b1, 32'h55, rd);
      check("pre_rst_out", {24'd0, gpo}, 32'h55);
      @(negedge clk);
      adr = 3'd0; we = 1'b1; dat = 32'hFF; stb = 1'b1;
      @(posedge clk); #1;
      check("mid_ack", {31'd0, ack}, 32'd1);
      #2 rst = 1'b1;
      #1;
      check("async_rst_gpio_o", {24'd0, gpo}, 32'd0);
      check("async_rst_oe", {24'd0, oe}, 32'd0);
      check("async_rst_ack", {31'd0, ack}, 32'd0);
      stb = 1'b0;
      @(negedge clk); rst = 1'b0;
      bus(3'd0, 1'b0, 32'd0, rd);
      check("rst_out_read", rd, 32'd0);

      // Directed table with pins steady at 0x3C.
      pin = 8'h3C;
      repeat (3) @(posedge clk);
      vecs[0] = '{3'd0, 1'b1, 32'hFFFF_FFA5, 32'd0, 8'hA5, 8'h00};
      vecs[1] = '{3'd1, 1'b1, 32'h0000_010F, 32'd0, 8'hA5, 8'h0F};
      vecs[2] = '{3'd0, 1'b0, 32'd0, 32'h0000_00A5, 8'hA5, 8'h0F};
      vecs[3] = '{3'd1, 1'b0, 32'd0, 32'h0000_000F, 8'hA5, 8'h0F};
      vecs[4] = '{3'd2, 1'b0, 32'd0, 32'h0000_003C, 8'hA5, 8'h0F};
      vecs[5] = '{3'd2, 1'b1, 32'hFF, 32'd0, 8'hA5, 8'h0F};
      vecs[6] = '{3'd2, 1'b0, 32'd0, 32'h0000_003C, 8'hA5, 8'h0F};
      vecs[7] = '{3'd7, 1'b1, 32'hFF, 32'd0, 8'hA5, 8'h0F};
      vecs[8] = '{3'd7, 1'b0, 32'd0, 32'd0, 8'hA5, 8'h0F};
      vecs[9] = '{3'd6, 1'b0, 32'd0, 32'd0, 8'hA5, 8'h0F};
      for (int i = 0; i < 10; i++) begin
         bus(vecs[i].adr, vecs[i].we, vecs[i].dat, rd);
         if (!vecs[i].we) check($sformatf("tbl%0d_rd", i), rd, vecs[i].exp_rd);
         check($sformatf("tbl%0d_o", i), {24'd0, gpo}, {24'd0, vecs[i].exp_o});
         check($sformatf("tbl%0d_oe", i), {24'd0, oe}, {24'd0, vecs[i].exp_oe});
      end
      check("rdt_holds", rdt, 32'd0);

      // Stb held for four edges yields acks on the first and third.
      @(negedge clk);
      adr = 3'd1; we = 1'b0; stb = 1'b1;
      acks = 0;
      for (int c = 0; c < 4; c++) begin
         @(posedge clk); #1;
         check($sformatf("held_stb_ack%0d", c), {31'd0, ack}, (c % 2 == 0) ? 32'd1 : 32'd0);
         if (ack) acks++;
      end
      stb = 1'b0;
      check("held_stb_acks", acks, 32'd2);

      // Input capture latency: IN still old after one edge, new after two.
      @(negedge clk); pin = 8'h00;
      @(posedge clk); #1;
      check("in_lat1", {24'd0, dut.in_sync}, 32'h3C);
      @(posedge clk); #1;
      check("in_lat2", {24'd0, dut.in_sync}, 32'h00);
      repeat (2) @(posedge clk);

`ifdef SERVISIA_GPIO_EDGE_EN
      bus(3'd3, 1'b1, 32'hFF, rd);
      bus(3'd4, 1'b1, 32'hFF, rd);
      @(negedge clk); pin = 8'h01;
      repeat (4) @(posedge clk);
      @(negedge clk); pin = 8'h00;
      repeat (4) @(posedge clk);
      #1;
      check("edge_irq", {31'd0, irq}, 32'd1);
      bus(3'd3, 1'b0, 32'd0, rd);
      check("edge_rise", rd, 32'h01);
      bus(3'd4, 1'b0, 32'd0, rd);
      check("edge_fall", rd, 32'h01);
      bus(3'd3, 1'b1, 32'h01, rd);
      check("irq_fall_pending", {31'd0, irq}, 32'd1);
      bus(3'd4, 1'b1, 32'h01, rd);
      check("irq_cleared", {31'd0, irq}, 32'd0);
      bus(3'd3, 1'b0, 32'd0, rd);
      check("rise_cleared", rd, 32'd0);
      bus(3'd4, 1'b0, 32'd0, rd);
      check("fall_cleared", rd, 32'd0);
      // Rising edge lands on the same edge as a w1c of that bit.
      @(negedge clk); pin = 8'h01;
      @(posedge clk);
      @(posedge clk);
      bus(3'd3, 1'b1, 32'h01, rd);
      bus(3'd3, 1'b0, 32'd0, rd);
      check("set_beats_w1c", rd, 32'h01);
      @(negedge clk); pin = 8'h00;
      repeat (4) @(posedge clk);
`else
      @(negedge clk); pin = 8'hFF;
      repeat (4) @(posedge clk);
      @(negedge clk); pin = 8'h00;
      repeat (4) @(posedge clk);
      #1;
      check("noedge_irq", {31'd0, irq}, 32'd0);
      bus(3'd3, 1'b1, 32'hFF, rd);
      bus(3'd3, 1'b0, 32'd0, rd);
      check("noedge_rise_rd", rd, 32'd0);
      bus(3'd4, 1'b0, 32'd0, rd);
      check("noedge_fall_rd", rd, 32'd0);
`endif

      // Randomised traffic against the model.
      bus(3'd0, 1'b1, 32'd0, rd);
      bus(3'd1, 1'b1, 32'd0, rd);
      bus(3'd3, 1'b1, 32'hFF, rd);
      bus(3'd4, 1'b1, 32'hFF, rd);
      m_out = '0; m_dir = '0; m_rise = '0; m_fall = '0; m_pin = {24'd0, pin};
      for (int it = 0; it < 300; it++) begin
         int op;
         logic [2:0] a;
         logic [31:0] d;
         op = $urandom_range(0, 3);
         a  = 3'($urandom_range(0, 7));
         d  = $urandom;
         if (op == 0) begin
            nxt = W'($urandom);
            m_rise |= {24'd0, nxt} & ~m_pin;
            m_fall |= ~{24'd0, nxt} & m_pin & MASK;
            m_pin   = {24'd0, nxt};
            @(negedge clk); pin = nxt;
            repeat (4) @(posedge clk);
            #1;
         end else if (op == 1) begin
            bus(a, 1'b1, d, rd);
            case (a)
               3'd0: m_out = d & MASK;
               3'd1: m_dir = d & MASK;
               3'd3: m_rise &= ~d;
               3'd4: m_fall &= ~d;
               default: ;
            endcase
            check("rnd_gpio_o", {24'd0, gpo}, m_out);
            check("rnd_oe", {24'd0, oe}, m_dir);
         end else begin
            bus(a, 1'b0, 32'd0, rd);
            check($sformatf("rnd_rd_a%0d", a), rd, model_read(a));
         end
         check("rnd_irq", {31'd0, irq}, EDGE ? {31'd0, |(m_rise | m_fall)} : 32'd0);
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/servisia_gpio.md
# servisia_gpio

Parametrised bidirectional GPIO peripheral on the core's Wishbone peripheral port; successor to the output-only GPO. Provides per-pin output value and direction registers, a two-flop input synchroniser, and optional sticky rise/fall edge flags with a level interrupt. Sits between the core's `o_wb_*`/`i_wb_*` peripheral bus and the board pins, with pin tristating done at the top level from `gpio_oe_o`.

## Interface

- `WIDTH`, 8, number of pins; legal range 1..32.
- `wb_clk_i`  in  1  clock; all state on rising edge.
- `wb_rst_i`  in  1  asynchronous, active-high reset.
- `wb_adr_i`  in  3  word address (core `o_wb_adr[4:2]`).
- `wb_dat_i`  in  32  write data; bits `[WIDTH-1:0]` used.
- `wb_we_i`  in  1  write enable.
- `wb_stb_i`  in  1  strobe; held by master until ack.
- `wb_rdt_o`  out  32  read data, zero-extended above WIDTH.
- `wb_ack_o`  out  1  single-cycle acknowledge.
- `gpio_i`  in  WIDTH  asynchronous pin inputs.
- `gpio_o`  out  WIDTH  pin output values.
- `gpio_oe_o`  out  WIDTH  per-pin output enable (1 = drive).
- `irq_o`  out  1  level interrupt, OR of all edge flags.

## Operation

- Register map (word address): 0 OUT rw; 1 DIR rw; 2 IN ro; 3 RISE w1c; 4 FALL w1c; 5..7 read 0, writes ignored.
- `gpio_o` = OUT, `gpio_oe_o` = DIR, both directly from registers.
- IN = second synchroniser stage; a third register holds previous sample for edge detection. Sync runs on all pins regardless of DIR.
- Edge detect: RISE[i] set when sync2[i]=1 and prev[i]=0; FALL[i] when sync2[i]=0 and prev[i]=1. Flags sticky until written 1 in the same bit; writing 0 leaves flag unchanged.
- Simultaneous set and w1c on same bit in same cycle: set wins, flag stays 1.
- Writes to IN ignored. Write data bits above WIDTH ignored.
- `irq_o` registered: `|(RISE | FALL)` sampled each cycle.
- Bus FSM, two states: IDLE, ACK. IDLE with `wb_stb_i`=1 -> ACK: ack asserted, read data registered, write committed. ACK -> IDLE unconditionally; ack deasserted. Back-to-back transfers therefore take 2 cycles each; stb held high across ACK does not trigger a second access.
- `wb_rdt_o` holds value of last read; not zeroed outside ack.

## Timing

- Reset (async assert, sync-effective release): OUT, DIR, RISE, FALL, sync stages, prev, `wb_ack_o`, `wb_rdt_o`, `irq_o` all 0. `gpio_o`, `gpio_oe_o` 0 immediately on assertion.
- Access latency: stb sampled at edge k -> ack and rdt valid after edge k, register update visible on `gpio_o`/`gpio_oe_o` after edge k.
- Pin input: change sampled at edge n -> IN readable after edge n+1 -> edge flag set after edge n+2 -> `irq_o` high after edge n+3.
- Reset mid-transaction: ack dropped, access lost, master must reissue.
- Edge reg `prev` resets to 0: pin held high through reset release produces one RISE flag (defined behaviour).

## Configuration

- `SERVISIA_GPIO_EDGE_EN` defined: prev register, RISE/FALL flags, `irq_o` logic built as above.
- Undefined: no edge state; addresses 3 and 4 read 0, writes ignored; `irq_o` tied 0. Synchroniser and all other registers unchanged.

## Structure

- Package `servisia_gpio_pkg`: register word-address constants (OUT, DIR, IN, RISE, FALL) and FSM state enum.
- One sub-module: `servisia_sync`, WIDTH-parametrised two-flop synchroniser with async active-high reset to 0.
- Top-level integration replaces existing GPO instance; core `i_wb_rdt` driven directly from `wb_rdt_o`.

## Test plan

- Reset: assert `wb_rst_i` mid-write to OUT with WIDTH=8 -> `gpio_o`=0, `gpio_oe_o`=0, `wb_ack_o`=0 asynchronously; no write lands.
- Write OUT=0xA5, DIR=0x0F, read back -> ack 1 cycle after each stb, `gpio_o`=0xA5, `gpio_oe_o`=0x0F, reads return 0x000000A5 and 0x0000000F.
- Drive `gpio_i`=0x3C -> IN reads 0x3C from 2 cycles later; write 0xFF to IN -> IN unchanged.
- With EDGE_EN: `gpio_i` 0x00->0x01->0x00 -> RISE=0x01, FALL=0x01, `irq_o`=1; write RISE=0x01, FALL=0x01 -> both 0, `irq_o`=0 next cycle.
- Rising edge on pin 0 coinciding with w1c of RISE bit 0 -> RISE stays 0x01.
- Hold stb high for 4 cycles -> exactly two acks (cycles 1 and 3); read of address 6 -> 0; without EDGE_EN read of address 3 -> 0, `irq_o` stays 0.
